init_seq_counter: RTL

//   Frame sequencer that drives the 6-bit step count into the init-transfer control decoder.
//   On a start request it runs N_CMDS frames. Each frame sweeps count 0..CNT_MAX, and the decoder

---
 rtl/init_seq_counter_pkg.sv | 27 ++
 rtl/init_seq_counter_if.sv | 74 +++++++
 rtl/seq_tick_gen.sv | 54 +++++
 rtl/init_seq_counter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/init_seq_counter_pkg.sv
// -----------------------------------------------------------------------------
// init_seq_pkg
//   Shared types and constants for the init-transfer frame sequencer.
//   - state_t    : sequencer FSM states (IDLE / RUN / FINISH)
//   - CNT_W      : width of the step count driven to the control decoder
//   - DEF_*      : default parameter values for the sequencer
//   - idx_w()    : width of the command index, max(1, clog2(n))
// -----------------------------------------------------------------------------
package init_seq_pkg;

    localparam int CNT_W        = 6;
    localparam int DEF_CNT_MAX  = 47;
    localparam int DEF_N_CMDS   = 4;
    localparam int DEF_TICK_DIV = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // A single-frame sequence still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/init_seq_counter_if.sv
// -----------------------------------------------------------------------------
// init_seq_counter_if
//   Bundle between the frame sequencer and the top-level init controller /
//   control decoder.
//   Signals:
//     start     : level-sampled sequence request (controller -> sequencer)
//     count     : 6-bit step count to the control decoder
//     cmd_idx   : current frame index 0..N_CMDS-1
//     frame_end : 1-cycle pulse when a non-final frame wraps
//     busy      : high while a sequence is running
//     done      : 1-cycle pulse at sequence completion
//     pause     : freeze request, present only when INIT_SEQ_PAUSE_EN is defined
//   Modports:
//     master : the sequencer side (drives count/status)
//     slave  : the controller side (drives start/pause)
// -----------------------------------------------------------------------------
interface init_seq_counter_if
    import init_seq_pkg::*;
#(
    parameter int N_CMDS = DEF_N_CMDS
);

    localparam int W = idx_w(N_CMDS);

    logic             start;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     cmd_idx;
    logic             frame_end;
    logic             busy;
    logic             done;

`ifdef INIT_SEQ_PAUSE_EN
    logic             pause;

    modport master (
        input  start,
        input  pause,
        output count,
        output cmd_idx,
        output frame_end,
        output busy,
        output done
    );

    modport slave (
        output start,
        output pause,
        input  count,
        input  cmd_idx,
        input  frame_end,
        input  busy,
        input  done
    );
`else
    modport master (
        input  start,
        output count,
        output cmd_idx,
        output frame_end,
        output busy,
        output done
    );

    modport slave (
        output start,
        input  count,
        input  cmd_idx,
        input  frame_end,
        input  busy,
        input  done
    );
`endif

endinterface

// File: rtl/seq_tick_gen.sv
// -----------------------------------------------------------------------------
// seq_tick_gen
//   Step-rate divider for the frame sequencer: asserts tick once every
//   TICK_DIV enabled cycles. With TICK_DIV=1 the divider collapses to a
//   constant-zero register and tick is permanently 1.
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high reset (divider -> 0)
//     clr   : synchronous clear of the divider phase
//     hold  : freezes the divider phase (tick stays at its current level)
//     tick  : step strobe; the consumer must gate it with its own hold reason
// -----------------------------------------------------------------------------
module seq_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int             DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    if (TICK_DIV < 1) begin : g_bad_div
        $error("seq_tick_gen: TICK_DIV must be >= 1");
    end

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;

    always_comb begin
        div_next = div_reg;
        if (clr) begin
            div_next = '0;
        end else if (!hold) begin
            div_next = (div_reg == DIV_LAST) ? '0 : div_reg + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_next;
        end
    end

    // Tick fires on the last phase, so a freshly cleared divider holds the
    // first count value for a full TICK_DIV cycles.
    assign tick = (div_reg == DIV_LAST);

endmodule

// File: rtl/init_seq_counter.sv
// -----------------------------------------------------------------------------
// init_seq_counter
//   Frame sequencer for the init-transfer control decoder. A start request
//   in IDLE runs N_CMDS frames; each frame sweeps count 0..CNT_MAX, advancing
//   one step every TICK_DIV cycles. In IDLE count parks at CNT_MAX so the
//   decoder keeps its CLK1/CLK2 strobes low.
//   Ports:
//     clk   : system clock
//     reset : synchronous, active-high reset
//     bus   : init_seq_counter_if.master (start, [pause], count, cmd_idx,
//             frame_end, busy, done)
//   Parameters:
//     CNT_MAX  : last count of a frame, 35..63
//     N_CMDS   : frames per sequence, >= 1
//     TICK_DIV : cycles per count step, >= 1
//   Optional feature macro: INIT_SEQ_PAUSE_EN -- adds bus.pause, which
//     freezes stepping (count, cmd_idx and divider phase) while in RUN.
// -----------------------------------------------------------------------------
module init_seq_counter
    import init_seq_pkg::*;
#(
    parameter int CNT_MAX  = DEF_CNT_MAX,
    parameter int N_CMDS   = DEF_N_CMDS,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                clk,
    input  logic                reset,
    init_seq_counter_if.master  bus
);

    localparam int               W        = idx_w(N_CMDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
    localparam logic [W-1:0]     CMD_LAST = W'(N_CMDS - 1);

    if ((CNT_MAX < 35) || (CNT_MAX > 63)) begin : g_bad_cnt_max
        $error("init_seq_counter: CNT_MAX must be within 35..63");
    end
    if (N_CMDS < 1) begin : g_bad_n_cmds
        $error("init_seq_counter: N_CMDS must be >= 1");
    end

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [W-1:0]     cmd_reg, cmd_next;
    logic             frame_end_reg, frame_end_next;

    logic             pause_req;
    logic             run_active;
    logic             tick;
    logic             step;

`ifdef INIT_SEQ_PAUSE_EN
    assign pause_req = bus.pause;
`else
    assign pause_req = 1'b0;
`endif

    assign run_active = (state_reg == RUN);

    // Outside RUN the divider is held at phase 0, so every sequence starts
    // with a full-length first step. pause only matters in RUN because the
    // clear dominates everywhere else.
    seq_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (!run_active),
        .hold  (pause_req),
        .tick  (tick)
    );

    assign step = tick && run_active && !pause_req;

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        cmd_next       = cmd_reg;
        frame_end_next = 1'b0;

        case (state_reg)
            IDLE: begin
                count_next = CNT_LAST;
                cmd_next   = '0;
                if (bus.start) begin
                    state_next = RUN;
                    count_next = '0;
                end
            end

            RUN: begin
                if (step) begin
                    if (count_reg == CNT_LAST) begin
                        if (cmd_reg == CMD_LAST) begin
                            // Final frame: count stays parked at CNT_MAX.
                            state_next = FINISH;
                        end else begin
                            count_next     = '0;
                            cmd_next       = cmd_reg + W'(1);
                            frame_end_next = 1'b1;
                        end
                    end else begin
                        count_next = count_reg + CNT_W'(1);
                    end
                end
            end

            FINISH: begin
                state_next = IDLE;
                count_next = CNT_LAST;
                cmd_next   = '0;
            end

            default: begin
                state_next = IDLE;
                count_next = CNT_LAST;
                cmd_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= CNT_LAST;
            cmd_reg       <= '0;
            frame_end_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            cmd_reg       <= cmd_next;
            frame_end_reg <= frame_end_next;
        end
    end

    // busy and done decode directly from the state register; FINISH lasts
    // exactly one cycle, which makes done a single-cycle pulse.
    assign bus.count     = count_reg;
    assign bus.cmd_idx   = cmd_reg;
    assign bus.frame_end = frame_end_reg;
    assign bus.busy      = (state_reg == RUN);
    assign bus.done      = (state_reg == FINISH);

endmodule
